// File: rtl/psrm0_fire.sv
// psrm0_fire - spike-generation stage of the psrm0 neuron.
//
// Takes the registered, clamped membrane sum from the summation stage and
// compares it against the firing threshold. A crossing fires a one-cycle
// spike, and the neuron then stays refractory for REFRAC_CYCLES cycles. The
// leaky decay term v - (v >> DECAY_SHIFT) is fed back to the summation stage.
//
// Optional feature macro: PSRM0_ADAPTIVE_THRESH_EN
//   When it is defined, each spike raises the threshold offset by THRESH_STEP.
//   Each quiet, enabled INTEGRATE cycle lowers the offset by 1.
//
// Ports:
//   clk               clock, rising edge
//   reset             synchronous, active-high reset
//   i_enable          integration enable (INTEGRATE holds when low)
//   i_sum_voltage_ff  registered membrane sum from the summation stage
//   i_threshold       base firing threshold, 0 disables firing
//   i_count_clr       clears the spike counter (priority over increment)
//   o_cond_decay      decay term back to the summation stage (0 outside INTEGRATE)
//   o_spike           one-cycle registered spike pulse
//   o_state           0 INTEGRATE, 1 FIRE, 2 REFRACTORY
//   o_spike_count     saturating spike count
module psrm0_fire #(
  parameter int WIDTH         = 14,
  parameter int DECAY_SHIFT   = 3,
  parameter int REFRAC_CYCLES = 4,
  parameter int V_RESET       = 0,
  parameter int THRESH_STEP   = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_sum_voltage_ff,
  input  logic [WIDTH-1:0] i_threshold,
  input  logic             i_count_clr,
  output logic [WIDTH-1:0] o_cond_decay,
  output logic             o_spike,
  output logic [1:0]       o_state,
  output logic [15:0]      o_spike_count
);

  typedef enum logic [1:0] {
    ST_INTEGRATE  = 2'd0,
    ST_FIRE       = 2'd1,
    ST_REFRACTORY = 2'd2
  } state_t;

  localparam int CW = $clog2(REFRAC_CYCLES + 2);
  localparam logic [CW-1:0] REFRAC_LOAD =
    (REFRAC_CYCLES > 0) ? CW'(REFRAC_CYCLES - 1) : '0;
  localparam logic [WIDTH-1:0] V_RST = WIDTH'(V_RESET);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] v_mem;
  logic [CW-1:0]    refrac_cnt;
  logic             spike_q;
  logic [15:0]      spike_count;
  logic [WIDTH-1:0] eff_thresh;
  logic             fire_now;

`ifdef PSRM0_ADAPTIVE_THRESH_EN
  logic [WIDTH-1:0] thresh_ofs;
  logic [WIDTH:0]   thr_sum;
  logic [WIDTH:0]   ofs_step;

  // One extra bit on each add catches the carry, and any overflow saturates.
  always_comb begin
    thr_sum    = {1'b0, i_threshold} + {1'b0, thresh_ofs};
    eff_thresh = thr_sum[WIDTH] ? '1 : thr_sum[WIDTH-1:0];
    ofs_step   = {1'b0, thresh_ofs} + (WIDTH+1)'(THRESH_STEP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      thresh_ofs <= '0;
    end else if (fire_now) begin
      thresh_ofs <= ofs_step[WIDTH] ? '1 : ofs_step[WIDTH-1:0];
    end else if (state == ST_INTEGRATE && i_enable && thresh_ofs != '0) begin
      thresh_ofs <= thresh_ofs - WIDTH'(1);
    end
  end
`else
  always_comb eff_thresh = i_threshold;
`endif

  always_comb begin
    fire_now = (state == ST_INTEGRATE) && i_enable && (i_threshold != '0) &&
               (i_sum_voltage_ff >= eff_thresh);
  end

  // State register plus datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_INTEGRATE;
      v_mem       <= '0;
      refrac_cnt  <= '0;
      spike_q     <= 1'b0;
      spike_count <= '0;
    end else begin
      state   <= state_nxt;
      spike_q <= fire_now;
      case (state)
        ST_INTEGRATE: begin
          if (i_enable) v_mem <= i_sum_voltage_ff;
        end
        ST_FIRE: begin
          v_mem      <= V_RST;
          refrac_cnt <= REFRAC_LOAD;
        end
        ST_REFRACTORY: begin
          v_mem <= V_RST;
          if (refrac_cnt != '0) refrac_cnt <= refrac_cnt - CW'(1);
        end
        default: v_mem <= V_RST;
      endcase
      // A clear in the same cycle as a new spike leaves exactly that spike counted
      if (i_count_clr)
        spike_count <= {15'd0, fire_now};
      else if (fire_now && spike_count != '1)
        spike_count <= spike_count + 16'd1;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INTEGRATE:  if (fire_now) state_nxt = ST_FIRE;
      ST_FIRE:       state_nxt = (REFRAC_CYCLES == 0) ? ST_INTEGRATE : ST_REFRACTORY;
      ST_REFRACTORY: if (refrac_cnt == '0) state_nxt = ST_INTEGRATE;
      default:       state_nxt = ST_INTEGRATE;
    endcase
  end

  // Outputs
  always_comb begin
    o_cond_decay  = '0;
    if (state == ST_INTEGRATE)
      o_cond_decay = v_mem - (v_mem >> DECAY_SHIFT);
    o_spike       = spike_q;
    o_state       = state;
    o_spike_count = spike_count;
  end

endmodule

// File: tb/tb_psrm0_fire.sv
module tb_psrm0_fire;

  typedef struct {
    logic        rst;
    logic        en;
    logic        clr;
    logic [13:0] sum;
    logic [13:0] thr;
    logic        exp_spike;
    logic [1:0]  exp_state;
    logic [13:0] exp_decay;
    logic [15:0] exp_count;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (REFRAC_CYCLES=4)
  logic        reset, en, clr;
  logic [13:0] sum, thr, decay;
  logic        spike;
  logic [1:0]  state;
  logic [15:0] count;

  // Second DUT with no refractory period
  logic        reset0, en0, clr0;
  logic [13:0] sum0, thr0, decay0;
  logic        spike0;
  logic [1:0]  state0;
  logic [15:0] count0;

  psrm0_fire #(.WIDTH(14), .DECAY_SHIFT(3), .REFRAC_CYCLES(4), .V_RESET(0), .THRESH_STEP(64)) dut (
    .clk(clk), .reset(reset), .i_enable(en), .i_sum_voltage_ff(sum), .i_threshold(thr),
    .i_count_clr(clr), .o_cond_decay(decay), .o_spike(spike), .o_state(state),
    .o_spike_count(count));

  psrm0_fire #(.WIDTH(14), .DECAY_SHIFT(3), .REFRAC_CYCLES(0), .V_RESET(0), .THRESH_STEP(64)) dut0 (
    .clk(clk), .reset(reset0), .i_enable(en0), .i_sum_voltage_ff(sum0), .i_threshold(thr0),
    .i_count_clr(clr0), .o_cond_decay(decay0), .o_spike(spike0), .o_state(state0),
    .o_spike_count(count0));

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  vec_t exp_q[$];
  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic e, input logic c,
                              input int s, input int t, input logic xs,
                              input int xst, input int xd, input int xc);
    vec_t v;
    v.rst = r; v.en = e; v.clr = c;
    v.sum = 14'(s); v.thr = 14'(t);
    v.exp_spike = xs; v.exp_state = 2'(xst);
    v.exp_decay = 14'(xd); v.exp_count = 16'(xc);
    return v;
  endfunction

  task automatic check(input string name, input vec_t e, input logic a_sp,
                       input logic [1:0] a_st, input logic [13:0] a_dec,
                       input logic [15:0] a_cnt);
    n_vec++;
    if (a_sp !== e.exp_spike || a_st !== e.exp_state ||
        a_dec !== e.exp_decay || a_cnt !== e.exp_count) begin
      n_err++;
      $display("FAIL %s: got spike=%0b state=%0d decay=%0d count=%0d, want spike=%0b state=%0d decay=%0d count=%0d",
               name, a_sp, a_st, a_dec, a_cnt,
               e.exp_spike, e.exp_state, e.exp_decay, e.exp_count);
    end
  endtask

  // Drive one vector, push its expectation, pop and compare after the edge
  task automatic apply(input string name, input vec_t v);
    vec_t e;
    reset = v.rst; en = v.en; clr = v.clr; sum = v.sum; thr = v.thr;
    exp_q.push_back(v);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    check(name, e, spike, state, decay, count);
  endtask

  task automatic apply0(input string name, input vec_t v);
    vec_t e;
    reset0 = v.rst; en0 = v.en; clr0 = v.clr; sum0 = v.sum; thr0 = v.thr;
    exp_q.push_back(v);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    check(name, e, spike0, state0, decay0, count0);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; clr = 1'b0; sum = '0; thr = '0;
    reset0 = 1'b1; en0 = 1'b0; clr0 = 1'b0; sum0 = '0; thr0 = '0;

    //                rst en clr sum     thr    spk st decay  count
    tbl.push_back(mk(1, 1, 0, 16383,  100,   0, 0, 0,     0)); // 0 reset
    tbl.push_back(mk(1, 1, 0, 16383,  100,   0, 0, 0,     0));
    tbl.push_back(mk(1, 1, 0, 16383,  100,   0, 0, 0,     0));
    tbl.push_back(mk(0, 1, 0, 800,    0,     0, 0, 700,   0)); // 3 leak
    tbl.push_back(mk(0, 0, 0, 5000,   0,     0, 0, 700,   0)); // 4 hold
    tbl.push_back(mk(0, 1, 0, 999,    1000,  0, 0, 875,   0)); // 5 just below
    tbl.push_back(mk(0, 1, 0, 1000,   1000,  1, 1, 0,     1)); // 6 equal fires
    tbl.push_back(mk(0, 1, 0, 5,      1000,  0, 2, 0,     1)); // 7 refractory
    tbl.push_back(mk(0, 1, 0, 5,      1000,  0, 2, 0,     1));
    tbl.push_back(mk(0, 1, 0, 5,      1000,  0, 2, 0,     1));
    tbl.push_back(mk(0, 1, 0, 5,      1000,  0, 2, 0,     1));
    tbl.push_back(mk(0, 1, 0, 5,      1000,  0, 0, 0,     1)); // 11 back, v=V_RESET
    tbl.push_back(mk(0, 1, 0, 16,     1000,  0, 0, 14,    1));
    tbl.push_back(mk(0, 1, 0, 2000,   1000,  1, 1, 0,     2)); // 13 sustained
    tbl.push_back(mk(0, 1, 0, 2000,   1000,  0, 2, 0,     2));
    tbl.push_back(mk(0, 1, 0, 2000,   1000,  0, 2, 0,     2));
    tbl.push_back(mk(0, 1, 0, 2000,   1000,  0, 2, 0,     2));
    tbl.push_back(mk(0, 1, 0, 2000,   1000,  0, 2, 0,     2));
    tbl.push_back(mk(0, 1, 0, 2000,   1000,  0, 0, 0,     2));
    tbl.push_back(mk(0, 1, 0, 2000,   1000,  1, 1, 0,     3)); // 19 six cycles later
    tbl.push_back(mk(0, 0, 0, 2000,   1000,  0, 2, 0,     3)); // 20 enable low, no stall
    tbl.push_back(mk(0, 0, 0, 2000,   1000,  0, 2, 0,     3));
    tbl.push_back(mk(0, 0, 0, 2000,   1000,  0, 2, 0,     3));
    tbl.push_back(mk(0, 0, 0, 2000,   1000,  0, 2, 0,     3));
    tbl.push_back(mk(0, 0, 0, 2000,   1000,  0, 0, 0,     3));
    tbl.push_back(mk(0, 0, 0, 2000,   1000,  0, 0, 0,     3)); // 25 disabled, no spike
    tbl.push_back(mk(0, 1, 1, 2000,   1000,  1, 1, 0,     1)); // 26 clr + spike
    tbl.push_back(mk(0, 1, 1, 2000,   1000,  0, 2, 0,     0)); // 27 clr alone
    tbl.push_back(mk(0, 1, 0, 0,      1000,  0, 2, 0,     0));
    tbl.push_back(mk(0, 1, 0, 0,      1000,  0, 2, 0,     0));
    tbl.push_back(mk(0, 1, 0, 0,      1000,  0, 2, 0,     0));
    tbl.push_back(mk(0, 1, 0, 0,      1000,  0, 0, 0,     0));
    tbl.push_back(mk(0, 1, 0, 16383,  0,     0, 0, 14336, 0)); // 32 thr=0 disables
    tbl.push_back(mk(0, 1, 0, 16383,  16383, 1, 1, 0,     1)); // 33 max thr
    tbl.push_back(mk(1, 1, 0, 2000,   1000,  0, 0, 0,     0)); // 34 reset in FIRE
    tbl.push_back(mk(1, 1, 0, 2000,   1000,  0, 0, 0,     0)); // 35 pending spike dropped
    tbl.push_back(mk(0, 1, 0, 2000,   1000,  1, 1, 0,     1)); // 36

    foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

    // No refractory period: spikes every 2 cycles
    apply0("rc0_rst", mk(1, 1, 0, 2000, 1000, 0, 0, 0, 0));
    for (int i = 0; i < 6; i++)
      apply0($sformatf("rc0_run%0d", i),
             mk(0, 1, 0, 2000, 1000, (i % 2 == 0), (i % 2 == 0) ? 1 : 0, 0, i / 2 + 1));

    // Counter saturation: preload just below the top
    force dut0.spike_count = 16'hFFFE;
    #1;
    release dut0.spike_count;
    apply0("sat_a", mk(0, 1, 0, 2000, 1000, 1, 1, 0, 65535));
    apply0("sat_b", mk(0, 1, 0, 2000, 1000, 0, 0, 0, 65535));
    apply0("sat_c", mk(0, 1, 0, 2000, 1000, 1, 1, 0, 65535));
    apply0("sat_d", mk(0, 1, 0, 2000, 1000, 0, 0, 0, 65535));
    apply0("sat_clr", mk(0, 1, 1, 2000, 1000, 1, 1, 0, 1));

`ifdef PSRM0_ADAPTIVE_THRESH_EN
    apply("ad_rst", mk(1, 1, 0, 0, 1000, 0, 0, 0, 0));
    apply("ad_fire", mk(0, 1, 0, 1000, 1000, 1, 1, 0, 1));
    for (int i = 0; i < 4; i++) apply("ad_ref", mk(0, 1, 0, 0, 1000, 0, 2, 0, 1));
    apply("ad_back", mk(0, 1, 0, 0, 1000, 0, 0, 0, 1));
    apply("ad_1063", mk(0, 1, 0, 1063, 1000, 0, 0, 931, 1));
    for (int i = 0; i < 63; i++) apply("ad_quiet", mk(0, 1, 0, 0, 1000, 0, 0, 0, 1));
    apply("ad_999", mk(0, 1, 0, 999, 1000, 0, 0, 875, 1));
    apply("ad_1000", mk(0, 1, 0, 1000, 1000, 1, 1, 0, 2));
    apply("ad_ref2", mk(0, 1, 0, 0, 1000, 0, 2, 0, 2));
    apply("ad_midrst", mk(1, 1, 0, 0, 1000, 0, 0, 0, 0));
    apply("ad_ofs0", mk(0, 1, 0, 1000, 1000, 1, 1, 0, 1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
